// File: rtl/wide_add_pkg.sv
// Shared definitions for the sequential wide adder/subtractor.
//   SLICE_W : width of one arithmetic slice (the shared 16-bit adder).
//   state_t : control states of wide_add_seq.
package wide_add_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage : wide_add_pkg

// File: rtl/ahead_adder16.sv
// 16-bit two-level carry-lookahead adder, purely combinational.
// Four 4-bit groups produce group propagate/generate; a second lookahead
// level turns those into group carries, so no carry ripples across groups.
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry-in
//   sum   out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15
//   pm    out 1   block propagate (all 16 bits propagate)
//   gm    out 1   block generate (carry out independent of cin)
module ahead_adder16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout,
  output logic        pm,
  output logic        gm
);

  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [3:0]  gc;

  // NOTE: every variable is assigned on every pass through this block, so
  // no storage (latch) is implied; sequential code elsewhere uses <= only.
  always_comb begin
    p = a ^ b;
    g = a & b;

    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end

    // Second-level lookahead: carry into each group straight from cin.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);

    gm   = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
         | (gp[3] & gp[2] & gp[1] & gg[0]);
    pm   = &gp;
    cout = gm | (pm & cin);

    // Bit carries inside each group, expanded from that group's carry-in.
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
               | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end

    sum = p ^ c;
  end

endmodule : ahead_adder16

// File: rtl/wide_add_seq.sv
// Multi-cycle WORDS x 16-bit adder/subtractor built around one shared
// 16-bit lookahead slice. One slice is computed per cycle, LSB first, with
// the slice carry chained through a register.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready = idle)
//   in_a, in_b          16*WORDS-bit operands
//   in_sub              1: A-B, 0: A+B+in_cin
//   in_cin              carry-in for add, ignored for subtract
//   out_valid/out_ready result handshake
//   out_sum             16*WORDS-bit result (valid only with out_valid)
//   out_cout            carry out of the MSB slice (subtract: 1 = no borrow)
//   out_ovf             two's-complement signed overflow
//   busy                operation in progress
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SLICE_W*WORDS-1:0] in_a,
  input  logic [SLICE_W*WORDS-1:0] in_b,
  input  logic                     in_sub,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SLICE_W*WORDS-1:0] out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     busy
);

  localparam int                CNT_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORDS - 1);

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]                cnt_q;
  logic                            carry_q;
  logic [WORDS-1:0][SLICE_W-1:0]   a_q;
  logic [WORDS-1:0][SLICE_W-1:0]   b_q;     // already inverted for subtract
  logic [WORDS-1:0][SLICE_W-1:0]   sum_q;
  logic                            cout_q;
  logic                            ovf_q;
  logic                            valid_q;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               unused_pm;
  logic               unused_gm;
  logic               last_slice;

  assign slice_a    = a_q[cnt_q];
  assign slice_b    = b_q[cnt_q];
  assign last_slice = (cnt_q == LAST);

  ahead_adder16 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout),
    .pm   (unused_pm),
    .gm   (unused_gm)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_slice) state_d = DONE;
      end
      DONE: begin
        busy = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers.
  // NOTE: the operand and result registers are plain flops, not a RAM, so
  // they take the asynchronous reset like all other state; a reset mid-op
  // clears the partially written result as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            // Subtract is A + ~B + 1: invert B once here, seed carry with 1.
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= slice_sum;
          carry_q      <= slice_cout;
          cnt_q        <= cnt_q + 1'b1;
          if (last_slice) begin
            cout_q  <= slice_cout;
            // Overflow: operands share a sign and the result sign differs.
            ovf_q   <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
                       (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) valid_q <= 1'b0;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule : wide_add_seq

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq (WORDS = 4, 64-bit operands).
// A plain-arithmetic reference model predicts each result; one compare
// process checks every cycle out_valid is high, plus latency and spacing.
// Directed vectors also pin the model against hand-computed literals.
module tb_wide_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t q[$];
  res_t exp_r;
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   last_acc = 0;
  bit   pending_first = 0;
  bit   have_last     = 0;
  bit   b2b           = 0;

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: exact integer arithmetic, result wrapped to W bits.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    res_t                r;
    logic signed [W+1:0] sa;
    logic signed [W+1:0] sb;
    logic signed [W+1:0] sr;
    logic [W:0]          u;
    sa = $signed({{2{a[W-1]}}, a});
    sb = $signed({{2{b[W-1]}}, b});
    if (sub) begin
      r.sum  = a - b;
      r.cout = (a >= b);
      sr     = sa - sb;
    end else begin
      u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      r.sum  = u[W-1:0];
      r.cout = u[W];
      sr     = sa + sb + $signed({{(W+1){1'b0}}, cin});
    end
    // True signed result fits W bits iff its top two bits agree.
    r.ovf = (sr[W] != sr[W-1]);
    return r;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Compare process: model queue, per-cycle output checks, timing checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      pending_first = 0;
      have_last     = 0;
    end else begin
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_sub, in_cin));
        if (b2b) begin
          if (have_last)
            check("accept_spacing", W'(cyc + 1 - last_acc), W'(WORDS + 2));
          have_last = 1;
          last_acc  = cyc + 1;
        end else begin
          have_last = 0;
        end
        acc_cyc       = cyc + 1;
        pending_first = 1;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", W'(out_valid), '0);
        end else begin
          exp_r = q[0];
          check("out_sum", out_sum, exp_r.sum);
          check("out_cout", W'(out_cout), W'(exp_r.cout));
          check("out_ovf", W'(out_ovf), W'(exp_r.ovf));
          check("busy_in_done", W'(busy), W'(1));
          check("in_ready_in_done", W'(in_ready), W'(0));
          if (pending_first) begin
            check("latency", W'(cyc - acc_cyc), W'(WORDS));
            pending_first = 0;
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  // Present an operand set and return just after the accept edge.
  task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin, input bit hold);
    bit ok;
    ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("accept_timeout", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("valid_timeout", W'(out_valid), W'(1));
  endtask

  // Directed op with hand-computed expectations; out_ready must be 1.
  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub, input logic cin,
                        input logic [W-1:0] e_sum, input logic e_cout,
                        input logic e_ovf);
    res_t r;
    r = model(a, b, sub, cin);
    check({name, "_model_sum"}, r.sum, e_sum);
    check({name, "_model_cout"}, W'(r.cout), W'(e_cout));
    check({name, "_model_ovf"}, W'(r.ovf), W'(e_ovf));
    drive_op(a, b, sub, cin, 0);
    wait_valid();
    check({name, "_sum"}, out_sum, e_sum);
    check({name, "_cout"}, W'(out_cout), W'(e_cout));
    check({name, "_ovf"}, W'(out_ovf), W'(e_ovf));
    @(posedge clk);
    #1;
    check({name, "_consumed"}, W'(out_valid), W'(0));
    check({name, "_idle"}, W'(in_ready), W'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] hold_sum;
    logic         hold_cout;
    logic         hold_ovf;
    bit           drained;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_out_sum", out_sum, '0);
    check("rst_out_cout", W'(out_cout), W'(0));
    check("rst_out_ovf", W'(out_ovf), W'(0));
    check("rst_in_ready", W'(in_ready), W'(1));
    #10;
    rst_n = 1'b1;

    // Directed arithmetic.
    run_op("full_carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b0);
    run_op("slice_carry", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("cin_add", 64'h1, 64'h1, 1'b0, 1'b1, 64'h3, 1'b0, 1'b0);
    run_op("sub_borrow", 64'h5, 64'h7, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_cin_ignored", 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);

    // Backpressure in DONE with new operands waiting upstream.
    out_ready = 1'b0;
    drive_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 0);
    wait_valid();
    check("bp_sum", out_sum, 64'h1234_5678_9ABC_DF00);
    hold_sum  = out_sum;
    hold_cout = out_cout;
    hold_ovf  = out_ovf;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 64'h0000_0000_0000_0010;
    in_b     = 64'h0000_0000_0000_0003;
    in_sub   = 1'b1;
    in_cin   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid_held", W'(out_valid), W'(1));
      check("bp_sum_held", out_sum, hold_sum);
      check("bp_cout_held", W'(out_cout), W'(hold_cout));
      check("bp_ovf_held", W'(out_ovf), W'(hold_ovf));
      check("bp_no_ready", W'(in_ready), W'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", W'(in_ready), W'(1));
    check("bp_release_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    check("bp_new_accepted", W'(busy), W'(1));
    in_valid = 1'b0;
    wait_valid();
    check("bp_new_sum", out_sum, 64'hD);
    @(posedge clk);
    #1;

    // Reset during slice 2 of a running operation.
    drive_op(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_run_valid", W'(out_valid), W'(0));
    check("rst_run_busy", W'(busy), W'(0));
    check("rst_run_sum", out_sum, '0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Reset while a result is held in DONE.
    out_ready = 1'b0;
    drive_op(64'h2, 64'h3, 1'b0, 1'b0, 0);
    wait_valid();
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_done_valid", W'(out_valid), W'(0));
    check("rst_done_busy", W'(busy), W'(0));
    check("rst_done_sum", out_sum, '0);
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;

    run_op("after_reset", 64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0);

    // Back-to-back random traffic, in_valid held high throughout.
    b2b = 1;
    for (int k = 0; k < 20; k++) begin
      drive_op({$urandom(), $urandom()}, {$urandom(), $urandom()},
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
    end
    in_valid = 1'b0;
    b2b      = 0;
    drained  = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        drained = 1;
        break;
      end
    end
    check("drain", W'(drained), W'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_wide_add_seq
